// File: rtl/db2_2_calc.sv
// db2_2_calc: accumulates delta2_2 over a mini-batch, scales by 2^-LR_SHIFT, negates,
// saturates to Q6.10 and strobes the result into the bias-2 register for one cycle.
module db2_2_calc #(
    parameter int BATCH    = 4,
    parameter int LR_SHIFT = 3,
    parameter int ACC_W    = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] delta2_2,
    input  logic               delta_valid,
    output logic [15:0]        db2_2,
    output logic               select_update,
    output logic               busy,
    output logic [7:0]         count
);
    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;
    localparam logic [7:0] LAST = 8'(BATCH - 1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(32768);
    state_t state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, q, n;
    logic [7:0] count_q, count_d;
    logic [15:0] db_q, db_d;
    assign q = acc_q >>> LR_SHIFT;
    assign n = -q;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        db_d    = db_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ACCUM;
                acc_d   = '0;
                count_d = '0;
            end
            ACCUM: if (delta_valid) begin
                acc_d   = acc_q + ACC_W'(delta2_2);
                count_d = count_q + 8'd1;
                state_d = (count_q == LAST) ? SCALE : ACCUM;
            end
            SCALE: begin
                db_d    = (n > MAXV) ? 16'h7fff : (n < MINV) ? 16'h8000 : n[15:0];
                state_d = OUT;
            end
            OUT: begin
                db_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            db_q    <= db_d;
        end
    end
    assign db2_2         = db_q;
    assign select_update = (state_q == OUT);
    assign busy          = (state_q != IDLE);
    assign count         = count_q;
endmodule

// File: tb/tb_db2_2_calc.sv
// tb_db2_2_calc: vector table run on two instances (LR_SHIFT=3 and LR_SHIFT=0) sharing stimulus,
// plus directed sequences for async reset, ignored inputs and back-to-back start.
module tb_db2_2_calc;
    logic clk = 0, reset = 1, start = 0, delta_valid = 0;
    logic signed [15:0] delta2_2 = '0;
    logic [15:0] db3, db0;
    logic sel3, sel0, busy3, busy0;
    logic [7:0] cnt3, cnt0;
    int n_cmp = 0, n_bad = 0;

    db2_2_calc #(.BATCH(4), .LR_SHIFT(3), .ACC_W(24)) u3 (
        .clk(clk), .reset(reset), .start(start), .delta2_2(delta2_2), .delta_valid(delta_valid),
        .db2_2(db3), .select_update(sel3), .busy(busy3), .count(cnt3));
    db2_2_calc #(.BATCH(4), .LR_SHIFT(0), .ACC_W(24)) u0 (
        .clk(clk), .reset(reset), .start(start), .delta2_2(delta2_2), .delta_valid(delta_valid),
        .db2_2(db0), .select_update(sel0), .busy(busy0), .count(cnt0));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s [4];
        int gap;
        logic [15:0] e3, e0;
    } vec_t;
    vec_t tv [7];

    task automatic set_vec(int i, logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d,
                           int g, logic [15:0] e3, logic [15:0] e0);
        tv[i].s[0] = a; tv[i].s[1] = b; tv[i].s[2] = c; tv[i].s[3] = d;
        tv[i].gap = g; tv[i].e3 = e3; tv[i].e0 = e0;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs a full batch; SCALE follows the 4th accepted sample, OUT the cycle after.
    task automatic run_batch(string tag, logic [15:0] s [4], int gap, logic [15:0] e3, logic [15:0] e0);
        start = 1;
        step();
        start = 0;
        check({tag, " busy after start"}, {31'd0, busy3}, 1);
        check({tag, " count after start"}, {24'd0, cnt3}, 0);
        for (int k = 0; k < 4; k++) begin
            delta_valid = 1;
            delta2_2 = s[k];
            step();
            delta_valid = 0;
            if (k < 3) for (int g = 0; g < gap; g++) step();
        end
        check({tag, " scale no strobe"}, {30'd0, sel3, sel0}, 0);
        check({tag, " scale count"}, {24'd0, cnt3}, 4);
        step();
        check({tag, " out strobe"}, {30'd0, sel3, sel0}, 32'd3);
        check({tag, " db lr3"}, {16'd0, db3}, {16'd0, e3});
        check({tag, " db lr0"}, {16'd0, db0}, {16'd0, e0});
        step();
        check({tag, " idle strobe low"}, {30'd0, sel3, sel0}, 0);
        check({tag, " idle busy low"}, {30'd0, busy3, busy0}, 0);
        check({tag, " idle db zero"}, {db3, db0}, 0);
    endtask

    logic [15:0] ones [4];

    initial begin
        set_vec(0, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 0, 16'hFE00, 16'hF000);
        set_vec(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 16'h0001, 16'h0004);
        set_vec(2, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 0, 16'h0000, 16'hFFFC);
        set_vec(3, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 16'hC001, 16'h8000);
        set_vec(4, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 16'h4000, 16'h7FFF);
        set_vec(5, 16'h0400, 16'hFC00, 16'h0200, 16'h0100, 2, 16'hFFA0, 16'hFD00);
        set_vec(6, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1, 16'hFDBA, 16'hEDCC);
        ones = tv[0].s;

        #2;
        check("reset outputs", {db3, 6'd0, sel3, busy3, cnt3}, 0);
        step();
        reset = 0;
        step();

        for (int i = 0; i < 7; i++) run_batch($sformatf("vec%0d", i), tv[i].s, tv[i].gap, tv[i].e3, tv[i].e0);

        // delta_valid in IDLE leaves count at the completed batch size
        delta_valid = 1; delta2_2 = 16'h0400;
        step(); step();
        delta_valid = 0;
        check("idle valid ignored", {24'd0, cnt3}, 4);
        check("idle valid no busy", {31'd0, busy3}, 0);

        // start during ACCUM does not restart; valid during SCALE/OUT not counted
        start = 1; step(); start = 0;
        delta_valid = 1; delta2_2 = 16'h0400;
        step(); step();
        start = 1;
        step();
        start = 0;
        check("start in accum ignored", {24'd0, cnt3}, 3);
        step();
        check("scale valid ignored", {24'd0, cnt3}, 4);
        step();
        check("out valid ignored", {24'd0, cnt3}, 4);
        check("out db after restart attempt", {16'd0, db3}, 32'hFE00);
        check("out strobe", {31'd0, sel3}, 1);
        delta_valid = 0;
        start = 1;
        step();
        check("start in out ignored", {31'd0, busy3}, 0);
        step();
        start = 0;
        check("start in next idle accepted", {31'd0, busy3}, 1);
        check("count cleared on start", {24'd0, cnt3}, 0);

        // async reset mid-batch after two samples, then a clean batch
        delta_valid = 1; delta2_2 = 16'h0400;
        step(); step();
        delta_valid = 0;
        check("two samples counted", {24'd0, cnt3}, 2);
        #2 reset = 1;
        #1;
        check("async reset busy", {30'd0, busy3, busy0}, 0);
        check("async reset count", {cnt3, cnt0}, 0);
        check("async reset strobe/db", {db3, 14'd0, sel3, sel0}, 0);
        step();
        check("no strobe after reset", {30'd0, sel3, sel0}, 0);
        reset = 0;
        step();
        run_batch("post-reset", ones, 0, 16'hFE00, 16'hF000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
